enemy_slot_controller: RTL



---
 rtl/enemy_pkg.sv | 16 +
 rtl/enemy_slot_controller_if.sv | 40 ++++
 rtl/slot_prio_enc.sv | 20 ++
 rtl/enemy_slot_controller.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/enemy_pkg.sv
// Shared types and constants for the enemy slot bank.
package enemy_pkg;

  localparam int unsigned NUM_SLOTS_DEF = 8;
  localparam int unsigned SLOT_IDX_W    = $clog2(NUM_SLOTS_DEF);

  typedef logic [SLOT_IDX_W-1:0] slot_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    SEEK,
    PRESENT,
    DONE
  } scan_state_t;

endpackage

// File: rtl/enemy_slot_controller_if.sv
// Request/response bundle between wave/collision logic and the slot controller.
interface enemy_slot_controller_if
  import enemy_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int unsigned IDX_W     = SLOT_IDX_W
);

  logic                 spawn_req;
  logic                 spawn_ack;
  logic                 spawn_nack;
  logic [IDX_W-1:0]     spawn_idx;
  logic                 kill_req;
  logic [IDX_W-1:0]     kill_idx;
  logic                 clear_all;
  logic                 scan_start;
  logic                 scan_valid;
  logic [IDX_W-1:0]     scan_idx;
  logic                 scan_ready;
  logic                 scan_busy;
  logic                 scan_done;
  logic [NUM_SLOTS-1:0] occupancy;
  logic [IDX_W:0]       free_count;
  logic                 full;
  logic                 empty;
  logic                 wave_clear;

  modport master (
    output spawn_req, kill_req, kill_idx, clear_all, scan_start, scan_ready,
    input  spawn_ack, spawn_nack, spawn_idx, scan_valid, scan_idx, scan_busy,
           scan_done, occupancy, free_count, full, empty, wave_clear
  );

  modport slave (
    input  spawn_req, kill_req, kill_idx, clear_all, scan_start, scan_ready,
    output spawn_ack, spawn_nack, spawn_idx, scan_valid, scan_idx, scan_busy,
           scan_done, occupancy, free_count, full, empty, wave_clear
  );

endinterface

// File: rtl/slot_prio_enc.sv
// Lowest-set-bit encoder: reports whether any bit is set and the lowest such index.
module slot_prio_enc #(
  parameter int unsigned W  = 8,
  parameter int unsigned IW = 3
) (
  input  logic [W-1:0]  vec,
  output logic          hit_c,
  output logic [IW-1:0] idx_c
);

  // Descending walk so the lowest set bit is the last one written.
  always_comb begin
    hit_c = |vec;
    idx_c = '0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (vec[i]) idx_c = IW'(i);
    end
  end

endmodule

// File: rtl/enemy_slot_controller.sv
// Enemy slot occupancy allocator with a valid/ready scan sequencer.
// Define ENEMY_SLOT_ROUND_ROBIN_EN to rotate the spawn search start after each allocation.
module enemy_slot_controller
  import enemy_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int unsigned IDX_W     = SLOT_IDX_W
) (
  input logic                     clock,
  input logic                     reset,
  enemy_slot_controller_if.slave  bus
);

  localparam int unsigned CNT_W = IDX_W + 1;

  logic [NUM_SLOTS-1:0] occ_q, occ_n;
  logic [CNT_W-1:0]     free_count_q, free_count_n;
  logic                 full_q, empty_q;
  logic                 spawn_ack_q, spawn_ack_n, spawn_nack_q, spawn_nack_n;
  logic [IDX_W-1:0]     spawn_idx_q, spawn_idx_n;
  logic                 wave_clear_q, wave_clear_n;

  scan_state_t          state_q, state_n;
  logic [IDX_W-1:0]     ptr_q, ptr_n, scan_idx_q, scan_idx_n;
  logic                 scan_valid_q, scan_valid_n, scan_done_q, scan_done_n, scan_busy_q;

  logic                 free_hit_c, alloc_hit_c, scan_hit_c;
  logic [IDX_W-1:0]     free_idx_c, alloc_idx_c, scan_hit_idx_c;
  logic [NUM_SLOTS-1:0] scan_vec_c;

  slot_prio_enc #(.W(NUM_SLOTS), .IW(IDX_W)) u_free_enc (
    .vec(~occ_q), .hit_c(free_hit_c), .idx_c(free_idx_c)
  );

`ifdef ENEMY_SLOT_ROUND_ROBIN_EN
  logic [IDX_W-1:0]     last_q, rr_start_c, rr_idx_c;
  logic [NUM_SLOTS-1:0] rr_vec_c;
  logic                 rr_hit_c;

  // Free slots at or above the rotating start; fall back to lowest free on wrap.
  always_comb begin
    rr_start_c = (32'(last_q) == NUM_SLOTS - 1) ? '0 : last_q + IDX_W'(1);
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      rr_vec_c[i] = !occ_q[i] && (i >= 32'(rr_start_c));
    end
  end

  slot_prio_enc #(.W(NUM_SLOTS), .IW(IDX_W)) u_rr_enc (
    .vec(rr_vec_c), .hit_c(rr_hit_c), .idx_c(rr_idx_c)
  );

  assign alloc_hit_c = free_hit_c;
  assign alloc_idx_c = rr_hit_c ? rr_idx_c : free_idx_c;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)            last_q <= IDX_W'(NUM_SLOTS - 1);
    else if (spawn_ack_n) last_q <= spawn_idx_n;
  end
`else
  assign alloc_hit_c = free_hit_c;
  assign alloc_idx_c = free_idx_c;
`endif

  // Bank update: kill and spawn both see pre-edge occupancy.
  always_comb begin
    occ_n        = occ_q;
    spawn_ack_n  = 1'b0;
    spawn_nack_n = 1'b0;
    spawn_idx_n  = spawn_idx_q;
    wave_clear_n = 1'b0;
    if (bus.clear_all) begin
      occ_n = '0;
    end else begin
      if (bus.kill_req && (32'(bus.kill_idx) < NUM_SLOTS)) occ_n[bus.kill_idx] = 1'b0;
      if (bus.spawn_req) begin
        if (alloc_hit_c) begin
          occ_n[alloc_idx_c] = 1'b1;
          spawn_ack_n        = 1'b1;
          spawn_idx_n        = alloc_idx_c;
        end else begin
          spawn_nack_n = 1'b1;
        end
      end
      wave_clear_n = bus.kill_req && (occ_q != '0) && (occ_n == '0);
    end
  end

  always_comb begin
    free_count_n = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      free_count_n = free_count_n + CNT_W'(!occ_n[i]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occ_q        <= '0;
      free_count_q <= CNT_W'(NUM_SLOTS);
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      spawn_ack_q  <= 1'b0;
      spawn_nack_q <= 1'b0;
      spawn_idx_q  <= '0;
      wave_clear_q <= 1'b0;
    end else begin
      occ_q        <= occ_n;
      free_count_q <= free_count_n;
      full_q       <= &occ_n;
      empty_q      <= ~|occ_n;
      spawn_ack_q  <= spawn_ack_n;
      spawn_nack_q <= spawn_nack_n;
      spawn_idx_q  <= spawn_idx_n;
      wave_clear_q <= wave_clear_n;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      scan_vec_c[i] = occ_q[i] && (i >= 32'(ptr_q));
    end
  end

  slot_prio_enc #(.W(NUM_SLOTS), .IW(IDX_W)) u_scan_enc (
    .vec(scan_vec_c), .hit_c(scan_hit_c), .idx_c(scan_hit_idx_c)
  );

  // Scan FSM next-state; scan_done is raised on entry to DONE so it lines up with that state.
  always_comb begin
    state_n      = state_q;
    ptr_n        = ptr_q;
    scan_idx_n   = scan_idx_q;
    scan_valid_n = scan_valid_q;
    scan_done_n  = 1'b0;
    if (bus.clear_all) begin
      state_n      = IDLE;
      scan_valid_n = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.scan_start) begin
            ptr_n   = '0;
            state_n = SEEK;
          end
        end
        SEEK: begin
          if (scan_hit_c) begin
            scan_idx_n   = scan_hit_idx_c;
            scan_valid_n = 1'b1;
            state_n      = PRESENT;
          end else begin
            state_n     = DONE;
            scan_done_n = 1'b1;
          end
        end
        PRESENT: begin
          if (bus.scan_ready) begin
            scan_valid_n = 1'b0;
            if (32'(scan_idx_q) == NUM_SLOTS - 1) begin
              state_n     = DONE;
              scan_done_n = 1'b1;
            end else begin
              ptr_n   = scan_idx_q + IDX_W'(1);
              state_n = SEEK;
            end
          end
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      scan_idx_q   <= '0;
      scan_valid_q <= 1'b0;
      scan_done_q  <= 1'b0;
      scan_busy_q  <= 1'b0;
    end else begin
      state_q      <= state_n;
      ptr_q        <= ptr_n;
      scan_idx_q   <= scan_idx_n;
      scan_valid_q <= scan_valid_n;
      scan_done_q  <= scan_done_n;
      scan_busy_q  <= (state_n != IDLE);
    end
  end

  assign bus.spawn_ack  = spawn_ack_q;
  assign bus.spawn_nack = spawn_nack_q;
  assign bus.spawn_idx  = spawn_idx_q;
  assign bus.scan_valid = scan_valid_q;
  assign bus.scan_idx   = scan_idx_q;
  assign bus.scan_busy  = scan_busy_q;
  assign bus.scan_done  = scan_done_q;
  assign bus.occupancy  = occ_q;
  assign bus.free_count = free_count_q;
  assign bus.full       = full_q;
  assign bus.empty      = empty_q;
  assign bus.wave_clear = wave_clear_q;

endmodule
